ifs_deser_align: RTL and testbench

- Consumes the registered 1-bit serial sample produced by an input-register primitive (SCLK domain, PD-forced-high capable).
- Deserializes the sample stream MSB-first into W-bit words.
- Hunts for and locks onto a framing sync word, then delivers the payload words over a valid/ready interface to the downstream fabric logic.
- First fabric stage behind the I/O register ring.

---
 rtl/ifs_deser_pkg.sv | 25 ++
 rtl/ifs_deser_shift.sv | 37 +++
 rtl/ifs_deser_align.sv | 130 +++++++++++++
 tb/tb_ifs_deser_align.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifs_deser_pkg.sv
// Shared types, default framing constants and counter-width helper for the
// ifs_deser_align serial-to-word framer.
package ifs_deser_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int         DEF_W           = 8;
  localparam logic [7:0] DEF_SYNC        = 8'hA5;
  localparam int         DEF_FRAME_WORDS = 4;
  localparam int         DEF_LOCK_CNT    = 2;
  localparam int         DEF_MISS_MAX    = 2;

  // Bits needed to hold values 0..n-1, never less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ifs_deser_shift.sv
// MSB-first shift register and bit counter; flags the EN cycle carrying the
// last bit of a word. align restarts word timing after a HUNT match.
module ifs_deser_shift
  import ifs_deser_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         SCLK,
  input  logic         RSTN,
  input  logic         EN,
  input  logic         SDI,
  input  logic         align,
  output logic [W-1:0] sr_next,
  output logic         word_done
);

  localparam int CW = clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  sr;
  logic [CW-1:0] bitcnt;

  assign sr_next   = EN ? {sr[W-2:0], SDI} : sr;
  assign word_done = EN && (bitcnt == LAST);

  always_ff @(posedge SCLK) begin
    if (!RSTN) begin
      sr     <= '0;
      bitcnt <= '0;
    end else if (EN) begin
      sr <= sr_next;
      if (align || bitcnt == LAST) bitcnt <= '0;
      else                         bitcnt <= bitcnt + 1'b1;
    end
  end

endmodule

// File: rtl/ifs_deser_align.sv
// Frame hunter/aligner: locks onto SYNC and delivers payload words over
// valid/ready. Define IFS_DESER_ERRCNT_EN to add the ERRCNT sync-error counter.
module ifs_deser_align
  import ifs_deser_pkg::*;
#(
  parameter int           W           = DEF_W,
  parameter logic [W-1:0] SYNC        = W'(DEF_SYNC),
  parameter int           FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int           LOCK_CNT    = DEF_LOCK_CNT,
  parameter int           MISS_MAX    = DEF_MISS_MAX
) (
  input  logic         SCLK,
  input  logic         RSTN,
  input  logic         SDI,
  input  logic         EN,
  output logic [W-1:0] DOUT,
  output logic         DVALID,
  input  logic         DREADY,
  output logic         LOCKED,
  output logic         OVF,
`ifdef IFS_DESER_ERRCNT_EN
  output logic [15:0]  ERRCNT,
`endif
  input  logic         OVF_CLR
);

  localparam int GW = clog2(LOCK_CNT + 1);
  localparam int MW = clog2(MISS_MAX + 1);
  localparam int IW = clog2(FRAME_WORDS + 1);

  state_t          state;
  logic [GW-1:0]   good;
  logic [MW-1:0]   miss;
  logic [IW-1:0]   wordidx;
  logic [W-1:0]    sr_next;
  logic            word_done;
  logic            sync_ok;
  logic            align;
  logic            in_frame;
  logic            new_word;
  logic            out_free;

  ifs_deser_shift #(.W(W)) u_shift (
    .SCLK      (SCLK),
    .RSTN      (RSTN),
    .EN        (EN),
    .SDI       (SDI),
    .align     (align),
    .sr_next   (sr_next),
    .word_done (word_done)
  );

  assign sync_ok  = (sr_next == SYNC);
  assign align    = EN && (state == ST_HUNT) && sync_ok;
  assign in_frame = (state != ST_HUNT);
  assign new_word = (state == ST_LOCKED) && word_done && (wordidx != '0);
  assign out_free = !DVALID || DREADY;

  always_ff @(posedge SCLK) begin
    if (!RSTN) begin
      state   <= ST_HUNT;
      good    <= '0;
      miss    <= '0;
      wordidx <= '0;
      LOCKED  <= 1'b0;
      DOUT    <= '0;
      DVALID  <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      if (align) begin
        good    <= GW'(1);
        miss    <= '0;
        wordidx <= IW'(1);
        if (LOCK_CNT == 1) begin
          state  <= ST_LOCKED;
          LOCKED <= 1'b1;
        end else begin
          state  <= ST_VERIFY;
        end
      end else if (in_frame && word_done) begin
        wordidx <= (wordidx == IW'(FRAME_WORDS)) ? '0 : wordidx + 1'b1;
        if (wordidx == '0) begin
          if (state == ST_VERIFY) begin
            if (sync_ok) begin
              good <= good + 1'b1;
              if (good == GW'(LOCK_CNT - 1)) begin
                state  <= ST_LOCKED;
                LOCKED <= 1'b1;
              end
            end else begin
              state <= ST_HUNT;
              good  <= '0;
            end
          end else if (sync_ok) begin
            miss <= '0;
          end else if (miss == MW'(MISS_MAX - 1)) begin
            state  <= ST_HUNT;
            LOCKED <= 1'b0;
            miss   <= '0;
          end else begin
            miss <= miss + 1'b1;
          end
        end
      end

      // A word arriving while the previous one is still held is dropped.
      if (new_word && out_free) begin
        DOUT   <= sr_next;
        DVALID <= 1'b1;
      end else if (DVALID && DREADY) begin
        DVALID <= 1'b0;
      end

      if (new_word && !out_free) OVF <= 1'b1;
      else if (OVF_CLR)          OVF <= 1'b0;
    end
  end

`ifdef IFS_DESER_ERRCNT_EN
  logic err_inc;
  assign err_inc = (state == ST_LOCKED) && word_done && (wordidx == '0) && !sync_ok;

  always_ff @(posedge SCLK) begin
    if (!RSTN)                           ERRCNT <= '0;
    else if (OVF_CLR)                    ERRCNT <= err_inc ? 16'd1 : 16'd0;
    else if (err_inc && ERRCNT != 16'hFFFF) ERRCNT <= ERRCNT + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ifs_deser_align.sv
// Randomized scoreboard bench for ifs_deser_align against a bit-level framing model.
module tb_ifs_deser_align;

  localparam int         W    = 8;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         FW   = 4;
  localparam int         LOCK = 2;
  localparam int         MISS = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sdi = 1'b0;
  logic       en = 1'b0;
  logic       dready = 1'b1;
  logic       ovf_clr = 1'b0;
  logic [7:0] dout;
  logic       dvalid;
  logic       locked;
  logic       ovf;
`ifdef IFS_DESER_ERRCNT_EN
  logic [15:0] errcnt;
`endif

  always #5 clk = ~clk;

  ifs_deser_align #(
    .W(W), .SYNC(SYNC), .FRAME_WORDS(FW), .LOCK_CNT(LOCK), .MISS_MAX(MISS)
  ) dut (
    .SCLK    (clk),
    .RSTN    (rstn),
    .SDI     (sdi),
    .EN      (en),
    .DOUT    (dout),
    .DVALID  (dvalid),
    .DREADY  (dready),
    .LOCKED  (locked),
    .OVF     (ovf),
`ifdef IFS_DESER_ERRCNT_EN
    .ERRCNT  (errcnt),
`endif
    .OVF_CLR (ovf_clr)
  );

  typedef struct {
    logic [7:0] data;
    int         cyc;
    bit         strict;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_popped = 0;

  // Reference model: framing state as plain integers over the bit stream.
  int         m_mode;
  int         m_good;
  int         m_miss;
  int         m_pos;
  int         m_slot;
  int         m_errs;
  logic [7:0] m_win;
  bit         exp_lock;
  bit         exp_ovf;
  int         drop_next = 0;
  int         en_gap = 0;
  bit         gap_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_good = 0; m_miss = 0; m_pos = 0; m_slot = 0; m_errs = 0;
    m_win = 8'h00;
  endtask

  task automatic model_bit(input bit b, output bit got, output logic [7:0] val);
    int cur;
    got = 1'b0;
    val = 8'h00;
    m_win = {m_win[6:0], b};
    if (m_mode == 0) begin
      if (m_win == SYNC) begin
        m_good = 1; m_miss = 0; m_pos = 0; m_slot = 1;
        m_mode = (LOCK == 1) ? 2 : 1;
      end
    end else begin
      m_pos++;
      if (m_pos == W) begin
        m_pos = 0;
        cur = m_slot;
        m_slot = (m_slot + 1) % (FW + 1);
        if (cur == 0) begin
          if (m_mode == 1) begin
            if (m_win == SYNC) begin
              m_good++;
              if (m_good == LOCK) m_mode = 2;
            end else begin
              m_mode = 0; m_good = 0;
            end
          end else if (m_win == SYNC) begin
            m_miss = 0;
          end else begin
            if (m_errs < 65535) m_errs++;
            m_miss++;
            if (m_miss == MISS) begin
              m_mode = 0; m_miss = 0;
            end
          end
        end else if (m_mode == 2) begin
          got = 1'b1;
          val = m_win;
        end
      end
    end
  endtask

  // One clock of stimulus; first checks the status the previous cycle produced.
  task automatic drive_cycle(input bit e, input bit d, input bit c);
    bit         got;
    bit         dropped;
    logic [7:0] val;
    item_t      it;
    @(negedge clk);
    chk("locked", 32'(locked), 32'(exp_lock));
    chk("ovf", 32'(ovf), 32'(exp_ovf));
`ifdef IFS_DESER_ERRCNT_EN
    chk("errcnt", 32'(errcnt), 32'(m_errs));
`endif
    en = e;
    sdi = d;
    ovf_clr = c;
    if (c) m_errs = 0;
    got = 1'b0;
    val = 8'h00;
    dropped = 1'b0;
    if (e) model_bit(d, got, val);
    if (got) begin
      if (drop_next > 0) begin
        drop_next--;
        dropped = 1'b1;
      end else begin
        it.data = val;
        it.cyc = cyc + 1;
        it.strict = dready;
        sb.push_back(it);
      end
    end
    exp_ovf = dropped ? 1'b1 : (c ? 1'b0 : exp_ovf);
    exp_lock = (m_mode == 2);
  endtask

  task automatic idle(input int n, input bit c);
    repeat (n) drive_cycle(1'b0, 1'($urandom), c);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n, input bit clr_last);
    int g;
    for (int i = n - 1; i >= 0; i--) begin
      g = gap_rand ? int'($urandom_range(0, 2)) : en_gap;
      repeat (g) drive_cycle(1'b0, 1'($urandom), 1'b0);
      drive_cycle(1'b1, v[i], clr_last && (i == 0));
    end
  endtask

  task automatic send_word(input logic [7:0] w, input bit clr_last);
    send_bits(w, 8, clr_last);
  endtask

  task automatic send_frame(input logic [7:0] s, input bit rnd);
    send_word(s, 1'b0);
    for (int k = 1; k <= FW; k++) send_word(rnd ? 8'($urandom) : 8'(k), 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    en = 1'b0;
    sdi = 1'b0;
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("rst_dvalid", 32'(dvalid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
`ifdef IFS_DESER_ERRCNT_EN
    chk("rst_errcnt", 32'(errcnt), 32'd0);
`endif
    rstn = 1'b1;
    sb.delete();
    model_reset();
    exp_lock = 1'b0;
    exp_ovf = 1'b0;
    drop_next = 0;
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #1;
      if (rstn && dvalid && dready) begin
        n_popped++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", dout, cyc);
        end else begin
          it = sb.pop_front();
          chk("dout", 32'(dout), 32'(it.data));
          if (it.strict) chk("latency", 32'(cyc), 32'(it.cyc));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    model_reset();
    exp_lock = 1'b0;
    exp_ovf = 1'b0;

    // Plain stream: 3 junk bits then 3 frames; only frames 2 and 3 deliver.
    do_reset();
    base = n_popped;
    send_bits(8'b011, 3, 1'b0);
    send_frame(SYNC, 1'b0);
    chk("no_lock_after_1st_sync", 32'(locked), 32'd0);
    send_frame(SYNC, 1'b0);
    send_frame(SYNC, 1'b0);
    idle(3, 1'b0);
    chk("plain_word_count", 32'(n_popped - base), 32'd8);

    // Sync corruption while locked.
    send_frame(SYNC, 1'b0);
    send_frame(8'h5A, 1'b0);
    chk("lock_kept_1_bad", 32'(locked), 32'd1);
    send_frame(SYNC, 1'b0);
    idle(1, 1'b1);
    send_frame(8'h5A, 1'b0);
    send_frame(8'h5A, 1'b0);
    chk("lock_lost_2_bad", 32'(locked), 32'd0);
    send_frame(8'h5A, 1'b0);
`ifdef IFS_DESER_ERRCNT_EN
    chk("errcnt_hold", 32'(errcnt), 32'd2);
`endif
    idle(1, 1'b1);
    idle(1, 1'b0);
`ifdef IFS_DESER_ERRCNT_EN
    chk("errcnt_clr", 32'(errcnt), 32'd0);
`endif
    send_frame(SYNC, 1'b1);
    send_frame(SYNC, 1'b1);
    send_frame(SYNC, 1'b1);
    chk("relock", 32'(locked), 32'd1);
    idle(3, 1'b0);

    // Same plain stream with EN on 1 of every 3 cycles.
    do_reset();
    base = n_popped;
    en_gap = 2;
    send_bits(8'b011, 3, 1'b0);
    repeat (3) send_frame(SYNC, 1'b0);
    idle(3, 1'b0);
    en_gap = 0;
    chk("gapped_word_count", 32'(n_popped - base), 32'd8);

    // Overflow: hold DREADY low across payload words.
    do_reset();
    base = n_popped;
    send_frame(SYNC, 1'b0);
    send_frame(SYNC, 1'b0);
    send_word(SYNC, 1'b0);
    dready = 1'b0;
    send_word(8'h01, 1'b0);
    idle(1, 1'b0);
    chk("held_dvalid", 32'(dvalid), 32'd1);
    chk("held_dout", 32'(dout), 32'h01);
    drop_next = 1;
    send_word(8'h02, 1'b0);
    idle(1, 1'b0);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("dout_unchanged", 32'(dout), 32'h01);
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("ovf_cleared", 32'(ovf), 32'd0);
    drop_next = 1;
    send_word(8'h03, 1'b1);
    idle(1, 1'b0);
    chk("ovf_set_wins", 32'(ovf), 32'd1);
    dready = 1'b1;
    send_word(8'h04, 1'b0);
    idle(3, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    chk("ovf_word_count", 32'(n_popped - base), 32'd6);

    // Reset while a word is pending.
    do_reset();
    send_frame(SYNC, 1'b1);
    send_frame(SYNC, 1'b1);
    send_word(SYNC, 1'b0);
    dready = 1'b0;
    send_word(8'h3C, 1'b0);
    idle(1, 1'b0);
    chk("pending_before_reset", 32'(dvalid), 32'd1);
    do_reset();
    dready = 1'b1;
    base = n_popped;
    send_frame(SYNC, 1'b0);
    chk("no_lock_one_fresh_sync", 32'(locked), 32'd0);
    send_frame(SYNC, 1'b0);
    idle(3, 1'b0);
    chk("relock_word_count", 32'(n_popped - base), 32'd4);

    // Random junk, syncs, payloads and EN gaps.
    do_reset();
    gap_rand = 1'b1;
    send_bits(8'($urandom), int'($urandom_range(1, 8)), 1'b0);
    for (int f = 0; f < 8; f++) begin
      send_frame(($urandom_range(0, 3) == 0) ? 8'h5A : SYNC, 1'b1);
    end
    gap_rand = 1'b0;
    idle(5, 1'b0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
